dic_alarm_sched: RTL and testbench

//   Alarm sequencer for the digital clock. Compares running clock digits against stored alarm digits.
//   On a match it rings for a bounded time, with snooze and dismiss driven by the console character detectors.

---
 rtl/dic_pkg.sv | 9 +
 rtl/dic_sec_timer.sv | 28 ++
 rtl/dic_alarm_sched.sv | 142 ++++++++++++++
 tb/tb_dic_alarm_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dic_pkg.sv
// Shared constants for the digital-clock alarm sequencer: FSM state codes and counter width.
package dic_pkg;
    localparam int CNT_W = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
    localparam logic [1:0] SNOOZE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
endpackage

// File: rtl/dic_sec_timer.sv
// Seconds counter shared by the RING and SNOOZE phases; the caller picks the limit.
module dic_sec_timer
    import dic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Clear wins over increment so a phase change always restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == limit);

endmodule

// File: rtl/dic_alarm_sched.sv
// Alarm sequencer: rings when the clock digits match the alarm digits, with bounded
// ring time, a limited number of snoozes, and dismiss from the console.
module dic_alarm_sched
    import dic_pkg::*;
#(
    parameter int RING_SECS   = 10,
    parameter int SNOOZE_SECS = 30,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_strb,
    input  logic       alarm_ena,
    input  logic       dicRun,
    input  logic [3:0] clkMtens,
    input  logic [3:0] clkMones,
    input  logic [3:0] clkStens,
    input  logic [3:0] clkSones,
    input  logic [3:0] alrMtens,
    input  logic [3:0] alrMones,
    input  logic [3:0] alrStens,
    input  logic [3:0] alrSones,
    input  logic       det_snooze,
    input  logic       det_cr,
    output logic       alarm_ring,
    output logic       beep,
    output logic       ring_start,
    output logic       snoozing,
    output logic [3:0] snz_left
);

    localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNZ_LIM  = CNT_W'(SNOOZE_SECS);
    localparam logic [3:0]       SNZ_MAX  = 4'(MAX_SNOOZE);

    logic [1:0]       state, stateNext;
    logic             phase, phaseNext;
    logic [3:0]       snzNext;
    logic             match;
    logic             timerClr, timerInc, timerDone;
    logic [CNT_W-1:0] timerLimit;

    assign match = (clkMtens == alrMtens) && (clkMones == alrMones) &&
                   (clkStens == alrStens) && (clkSones == alrSones);

    assign timerLimit = (state == SNOOZE) ? SNZ_LIM : RING_LIM;

    dic_sec_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timerClr),
        .inc   (timerInc),
        .limit (timerLimit),
        .done  (timerDone)
    );

    // Events (dismiss, snooze, timeout) are checked before sec_strb, so a strobe that
    // coincides with an event never advances the count.
    always_comb begin
        stateNext = state;
        phaseNext = phase;
        snzNext   = snz_left;
        timerClr  = 1'b0;
        timerInc  = 1'b0;
        if (!alarm_ena) begin
            stateNext = IDLE;
            timerClr  = 1'b1;
            snzNext   = SNZ_MAX;
        end else begin
            case (state)
                IDLE: begin
                    if (match && dicRun) begin
                        stateNext = RING;
                        timerClr  = 1'b1;
                        phaseNext = 1'b1;
                        snzNext   = SNZ_MAX;
                    end
                end
                RING: begin
                    if (det_cr) begin
                        stateNext = DONE;
                        timerClr  = 1'b1;
                    end else if (det_snooze) begin
                        timerClr = 1'b1;
                        if (snz_left != 4'd0) begin
                            stateNext = SNOOZE;
                            snzNext   = snz_left - 1'b1;
                        end else begin
                            stateNext = DONE;
                        end
                    end else if (timerDone) begin
                        stateNext = DONE;
                        timerClr  = 1'b1;
                    end else if (sec_strb) begin
                        timerInc  = 1'b1;
                        phaseNext = ~phase;
                    end
                end
                SNOOZE: begin
                    if (det_cr) begin
                        stateNext = DONE;
                        timerClr  = 1'b1;
                    end else if (timerDone) begin
                        stateNext = RING;
                        timerClr  = 1'b1;
                        phaseNext = 1'b1;
                    end else if (sec_strb) begin
                        timerInc = 1'b1;
                    end
                end
                default: begin
                    // DONE holds off a retrigger until the clock moves off the alarm time.
                    if (!match) begin
                        stateNext = IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            snz_left   <= SNZ_MAX;
            alarm_ring <= 1'b0;
            beep       <= 1'b0;
            ring_start <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= stateNext;
            phase      <= phaseNext;
            snz_left   <= snzNext;
            alarm_ring <= (stateNext == RING);
            beep       <= (stateNext == RING) && phaseNext;
            ring_start <= (stateNext == RING) && (state != RING);
            snoozing   <= (stateNext == SNOOZE);
        end
    end

endmodule

// File: tb/tb_dic_alarm_sched.sv
// Self-checking bench for dic_alarm_sched: vector table, directed corner sequences,
// and randomized traffic compared against a behavioural model every cycle.
module tb_dic_alarm_sched;

    localparam int RING_SECS   = 10;
    localparam int SNOOZE_SECS = 30;
    localparam int MAX_SNOOZE  = 3;

    logic        clk;
    logic        rst;
    logic        sec_strb;
    logic        alarm_ena;
    logic        dicRun;
    logic [15:0] clkDig;
    logic [15:0] alrDig;
    logic        det_snooze;
    logic        det_cr;
    logic        alarm_ring;
    logic        beep;
    logic        ring_start;
    logic        snoozing;
    logic [3:0]  snz_left;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_RING, M_SNZ, M_DONE} mState_t;
    mState_t mSt;
    int      mCnt;
    bit      mPh;
    int      mSnz;
    bit      mStart;

    typedef struct {
        logic [15:0] cd;
        logic [15:0] ad;
        logic        ena;
        logic        run;
        logic        expRing;
    } vec_t;

    vec_t vecs[8];

    dic_alarm_sched #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_strb   (sec_strb),
        .alarm_ena  (alarm_ena),
        .dicRun     (dicRun),
        .clkMtens   (clkDig[15:12]),
        .clkMones   (clkDig[11:8]),
        .clkStens   (clkDig[7:4]),
        .clkSones   (clkDig[3:0]),
        .alrMtens   (alrDig[15:12]),
        .alrMones   (alrDig[11:8]),
        .alrStens   (alrDig[7:4]),
        .alrSones   (alrDig[3:0]),
        .det_snooze (det_snooze),
        .det_cr     (det_cr),
        .alarm_ring (alarm_ring),
        .beep       (beep),
        .ring_start (ring_start),
        .snoozing   (snoozing),
        .snz_left   (snz_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mSt    = M_IDLE;
        mCnt   = 0;
        mPh    = 1'b0;
        mSnz   = MAX_SNOOZE;
        mStart = 1'b0;
    endtask

    task automatic modelRing();
        mSt  = M_RING;
        mCnt = 0;
        mPh  = 1'b1;
    endtask

    // Advance the alarm model by one clock using the inputs that were present at the edge.
    task automatic modelStep();
        bit hit;
        bit wasRing;
        hit     = (clkDig == alrDig);
        wasRing = (mSt == M_RING);
        if (rst) begin
            modelReset();
        end else if (!alarm_ena) begin
            mSt  = M_IDLE;
            mCnt = 0;
            mSnz = MAX_SNOOZE;
        end else begin
            case (mSt)
                M_IDLE: if (hit && dicRun) begin
                    modelRing();
                    mSnz = MAX_SNOOZE;
                end
                M_RING: begin
                    if (det_cr) mSt = M_DONE;
                    else if (det_snooze) begin
                        if (mSnz > 0) begin
                            mSt  = M_SNZ;
                            mCnt = 0;
                            mSnz = mSnz - 1;
                        end else begin
                            mSt = M_DONE;
                        end
                    end else if (mCnt >= RING_SECS) mSt = M_DONE;
                    else if (sec_strb) begin
                        mCnt = mCnt + 1;
                        mPh  = ~mPh;
                    end
                end
                M_SNZ: begin
                    if (det_cr) mSt = M_DONE;
                    else if (mCnt >= SNOOZE_SECS) modelRing();
                    else if (sec_strb) mCnt = mCnt + 1;
                end
                default: if (!hit) mSt = M_IDLE;
            endcase
        end
        mStart = (mSt == M_RING) && !wasRing;
    endtask

    task automatic checkModel();
        logic [7:0] act, exp;
        act = {alarm_ring, beep, ring_start, snoozing, snz_left};
        exp = {(mSt == M_RING), (mSt == M_RING) && mPh, mStart, (mSt == M_SNZ), 4'(mSnz)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL model ring/beep/start/snz/left actual=%b required=%b at %0t",
                     act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkModel();
    endtask

    task automatic applyStimulus(input logic [15:0] cd, input logic [15:0] ad,
                                 input logic ena, input logic run);
        clkDig    = cd;
        alrDig    = ad;
        alarm_ena = ena;
        dicRun    = run;
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            sec_strb = 1'b1;
            tick();
            sec_strb = 1'b0;
            tick();
        end
    endtask

    task automatic pulseSnooze();
        det_snooze = 1'b1;
        tick();
        det_snooze = 1'b0;
    endtask

    task automatic rearm();
        alarm_ena = 1'b0;
        tick();
        alarm_ena = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{16'h1235, 16'h1234, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h0234, 16'h1234, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{16'h5959, 16'h5959, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h1334, 16'h1234, 1'b1, 1'b1, 1'b0};

        rst        = 1'b1;
        sec_strb   = 1'b0;
        det_snooze = 1'b0;
        det_cr     = 1'b0;
        applyStimulus(16'h0000, 16'h1234, 1'b0, 1'b0);
        modelReset();
        tick();
        tick();
        #2 rst = 1'b0;
        checkOutput("resetOutputs", int'({alarm_ring, beep, ring_start, snoozing}), 0);
        checkOutput("resetSnzLeft", int'(snz_left), MAX_SNOOZE);

        for (int v = 0; v < 8; v++) begin
            alarm_ena = 1'b0;
            tick();
            applyStimulus(vecs[v].cd, vecs[v].ad, vecs[v].ena, vecs[v].run);
            tick();
            checkOutput($sformatf("vec%0dStart", v), int'(ring_start), int'(vecs[v].expRing));
            checkOutput($sformatf("vec%0dRing", v), int'(alarm_ring), int'(vecs[v].expRing));
        end

        // Ring times out after RING_SECS strobes and stays quiet while the time is held.
        alarm_ena = 1'b0;
        tick();
        applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b1);
        tick();
        checkOutput("autoStartPulse", int'(ring_start), 1);
        checkOutput("autoStartBeep", int'(beep), 1);
        strobe(RING_SECS - 1);
        checkOutput("ringBeforeLimit", int'(alarm_ring), 1);
        strobe(1);
        checkOutput("ringAfterLimit", int'(alarm_ring), 0);
        strobe(15);
        checkOutput("doneHeld", int'(alarm_ring), 0);
        clkDig = 16'h1235;
        tick();
        clkDig = 16'h1234;
        tick();
        checkOutput("retriggerAfterMove", int'(ring_start), 1);

        // Snooze after three strobes, then re-ring after the snooze period.
        rearm();
        strobe(3);
        pulseSnooze();
        tick();
        checkOutput("snoozeEntered", int'(snoozing), 1);
        checkOutput("snoozeLeft2", int'(snz_left), 2);
        strobe(SNOOZE_SECS);
        checkOutput("reRingStart", int'(ring_start), 1);
        checkOutput("reRingLevel", int'(alarm_ring), 1);

        // Use up the remaining snoozes; the one after that dismisses.
        pulseSnooze();
        strobe(SNOOZE_SECS);
        pulseSnooze();
        checkOutput("snoozeLeft0", int'(snz_left), 0);
        strobe(SNOOZE_SECS);
        checkOutput("thirdReRing", int'(ring_start), 1);
        pulseSnooze();
        tick();
        checkOutput("fourthSnoozeDismiss", int'({alarm_ring, snoozing}), 0);
        checkOutput("fourthSnoozeLeft", int'(snz_left), 0);
        strobe(SNOOZE_SECS + 5);
        checkOutput("noFurtherRing", int'(alarm_ring), 0);

        // Dismiss and snooze together: dismiss wins, snooze budget untouched.
        rearm();
        det_cr     = 1'b1;
        det_snooze = 1'b1;
        tick();
        det_cr     = 1'b0;
        det_snooze = 1'b0;
        checkOutput("crBeatsSnooze", int'({alarm_ring, snoozing}), 0);
        checkOutput("crKeepsSnzLeft", int'(snz_left), MAX_SNOOZE);

        // Dropping alarm_ena during SNOOZE returns to IDLE.
        rearm();
        pulseSnooze();
        checkOutput("snoozeBeforeDrop", int'(snoozing), 1);
        alarm_ena = 1'b0;
        tick();
        checkOutput("enaDropOutputs", int'({alarm_ring, beep, ring_start, snoozing}), 0);
        checkOutput("enaDropSnzLeft", int'(snz_left), MAX_SNOOZE);

        // Asynchronous reset in the middle of a ring.
        alarm_ena = 1'b1;
        tick();
        checkOutput("ringBeforeReset", int'(alarm_ring), 1);
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncResetRing", int'(alarm_ring), 0);
        alarm_ena = 1'b0;
        #1 rst = 1'b0;
        checkOutput("resetReleaseIdle", int'({alarm_ring, snoozing}), 0);
        checkOutput("resetReleaseLeft", int'(snz_left), MAX_SNOOZE);
        tick();

        // Randomized traffic against the model.
        applyStimulus(16'h0730, 16'h0730, 1'b1, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            sec_strb   = ($urandom_range(0, 3) == 0);
            det_snooze = ($urandom_range(0, 39) == 0);
            det_cr     = ($urandom_range(0, 59) == 0);
            alarm_ena  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) == 0) dicRun = ~dicRun;
            if ($urandom_range(0, 299) == 0) alrDig = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 0) clkDig = alrDig;
                else clkDig[3:0] = 4'($urandom_range(0, 9));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
